// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request arbiter.
// Command-register bit positions mirror the controller's command register.
package dma_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  localparam int CMD_DISABLE_BIT   = 2;
  localparam int CMD_ROTATE_BIT    = 4;
  localparam int CMD_DREQ_LOW_BIT  = 6;
  localparam int CMD_DACK_HIGH_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HLDA,
    SERVICE,
    RELEASE
  } dma_state_t;

endpackage

// File: rtl/dma_prio_encoder.sv
// Circular priority encoder: first set bit of pend searching
// upward from start_ptr, wrapping past the top channel.
module dma_prio_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0]   pend,
  input  logic [CH_IDX_W-1:0] start_ptr,
  output logic                found,
  output logic [CH_IDX_W-1:0] idx
);

  logic [NUM_CH-1:0]   w_rot;
  logic [CH_IDX_W-1:0] w_off;

  assign w_rot = NUM_CH'({pend, pend} >> start_ptr);

  // offset of the first request at or after start_ptr
  always_comb begin
    w_off = '0;
    priority case (1'b1)
      w_rot[0]: w_off = 2'd0;
      w_rot[1]: w_off = 2'd1;
      w_rot[2]: w_off = 2'd2;
      w_rot[3]: w_off = 2'd3;
      default:  w_off = '0;
    endcase
  end

  assign found = |w_rot;
  assign idx   = start_ptr + w_off;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA request arbiter and HRQ/HLDA bus-hold sequencer.
// Optional macro DMA_ROTATING_PRIORITY_EN builds the rotating-priority pointer.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   dreq,
  input  logic [NUM_CH-1:0]   masked_channels,
  input  logic                cmd_disable,
  input  logic                cmd_rotate,
  input  logic                cmd_dreq_low,
  input  logic                cmd_dack_high,
  input  logic                hlda,
  input  logic                xfer_done,
  output logic                hrq,
  output logic [NUM_CH-1:0]   dack,
  output logic [CH_IDX_W-1:0] active_ch,
  output logic                grant,
  output logic                xfer_start,
  output logic [NUM_CH-1:0]   req_status
);

  logic [NUM_CH-1:0]   r_sync [SYNC_STAGES];
  dma_state_t          r_state;
  dma_state_t          w_next;
  logic [CH_IDX_W-1:0] r_active;
  logic [CH_IDX_W-1:0] w_start;
  logic [CH_IDX_W-1:0] w_idx;
  logic                w_found;
  logic                w_latch;
  logic                w_go;
  logic                r_xfer_start;
  logic [NUM_CH-1:0]   w_pend;
  logic [NUM_CH-1:0]   w_onehot;

  // polarity-correct then synchronize; cleared value is "no request"
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= dreq ^ {NUM_CH{cmd_dreq_low}};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign req_status = r_sync[SYNC_STAGES-1];
  assign w_pend     = req_status & ~masked_channels;

`ifdef DMA_ROTATING_PRIORITY_EN
  logic [CH_IDX_W-1:0] r_ptr;

  // search restarts just past the channel that finished
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_ptr <= '0;
    else if (r_state == SERVICE && xfer_done) r_ptr <= r_active + 1'b1;
  end

  assign w_start = cmd_rotate ? r_ptr : '0;
`else
  logic w_unused_rotate;
  assign w_unused_rotate = cmd_rotate;
  assign w_start = '0;
`endif

  dma_prio_encoder u_enc (
    .pend      (w_pend),
    .start_ptr (w_start),
    .found     (w_found),
    .idx       (w_idx)
  );

  // next-state and handshake decisions
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_go    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!cmd_disable && w_found) begin
          w_next  = WAIT_HLDA;
          w_latch = 1'b1;
        end
      end
      WAIT_HLDA: begin
        if (!w_pend[r_active]) begin
          w_next = IDLE;
        end else if (hlda) begin
          w_next = SERVICE;
          w_go   = 1'b1;
        end
      end
      SERVICE: if (xfer_done) w_next = RELEASE;
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state, latched winner and start strobe
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_active     <= '0;
      r_xfer_start <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_xfer_start <= w_go;
      if (w_latch) r_active <= w_idx;
    end
  end

  assign w_onehot   = (r_state == SERVICE) ? (NUM_CH'(1) << r_active) : '0;
  assign dack       = cmd_dack_high ? w_onehot : ~w_onehot;
  assign hrq        = (r_state == WAIT_HLDA) || (r_state == SERVICE);
  assign grant      = (r_state == SERVICE);
  assign xfer_start = r_xfer_start;
  assign active_ch  = r_active;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter.
// Expected grant channels are queued at stimulus time and popped on grant.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       reset;
  logic [3:0] dreq;
  logic [3:0] masked_channels;
  logic       cmd_disable;
  logic       cmd_rotate;
  logic       cmd_dreq_low;
  logic       cmd_dack_high;
  logic       hlda;
  logic       xfer_done;
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] active_ch;
  logic       grant;
  logic       xfer_start;
  logic [3:0] req_status;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  dma_priority_arbiter dut (
    .CLK             (CLK),
    .reset           (reset),
    .dreq            (dreq),
    .masked_channels (masked_channels),
    .cmd_disable     (cmd_disable),
    .cmd_rotate      (cmd_rotate),
    .cmd_dreq_low    (cmd_dreq_low),
    .cmd_dack_high   (cmd_dack_high),
    .hlda            (hlda),
    .xfer_done       (xfer_done),
    .hrq             (hrq),
    .dack            (dack),
    .active_ch       (active_ch),
    .grant           (grant),
    .xfer_start      (xfer_start),
    .req_status      (req_status)
  );

  always #5 CLK = ~CLK;

  task automatic init_inputs();
    dreq = 4'b0000; masked_channels = 4'b0000;
    cmd_disable = 0; cmd_rotate = 0;
    cmd_dreq_low = 0; cmd_dack_high = 0;
    hlda = 0; xfer_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
  endtask

  // runs one full handshake and reports what was observed
  task automatic serve(input int dly, output bit ok,
                       output int t_hrq, output int t_gnt,
                       output logic [1:0] ch, output logic [3:0] dk,
                       output int starts, output logic [1:0] rel,
                       output logic [3:0] rel_dk);
    ok = 0; t_hrq = 0; t_gnt = 0; ch = 0; dk = 0;
    starts = 0; rel = 0; rel_dk = 0;
    while (hrq !== 1'b1 && t_hrq < 20) begin
      @(negedge CLK); t_hrq++;
    end
    if (hrq !== 1'b1) return;
    repeat (dly) @(negedge CLK);
    hlda = 1'b1;
    while (grant !== 1'b1 && t_gnt < 10) begin
      @(negedge CLK); t_gnt++;
    end
    if (grant !== 1'b1) begin hlda = 1'b0; return; end
    ok = 1; ch = active_ch; dk = dack; starts = int'(xfer_start);
    @(negedge CLK);
    starts += int'(xfer_start);
    xfer_done = 1'b1;
    @(negedge CLK);
    xfer_done = 1'b0;
    rel = {hrq, grant}; rel_dk = dack;
    hlda = 1'b0;
  endtask

  task automatic test_reset();
    init_inputs(); do_reset();
    n_tests++; if (hrq !== 1'b0) begin n_fail++; $display("FAIL rst_hrq got %b want 0", hrq); end
    n_tests++; if (grant !== 1'b0) begin n_fail++; $display("FAIL rst_grant got %b want 0", grant); end
    n_tests++; if (xfer_start !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b want 0", xfer_start); end
    n_tests++; if (active_ch !== 2'd0) begin n_fail++; $display("FAIL rst_ch got %0d want 0", active_ch); end
    n_tests++; if (dack !== 4'b1111) begin n_fail++; $display("FAIL rst_dack got %b want 1111", dack); end
    n_tests++; if (req_status !== 4'b0000) begin n_fail++; $display("FAIL rst_status got %b want 0000", req_status); end
    cmd_dack_high = 1'b1; #1;
    n_tests++; if (dack !== 4'b0000) begin n_fail++; $display("FAIL rst_dack_hi got %b want 0000", dack); end
    cmd_dack_high = 1'b0;
  endtask

  task automatic test_single();
    bit ok; int th, tg, st; logic [1:0] ch, rel; logic [3:0] dk, rdk; int e;
    init_inputs(); do_reset();
    dreq = 4'b0100; exp_q.push_back(2);
    serve(2, ok, th, tg, ch, dk, st, rel, rdk);
    dreq = 4'b0000;
    e = exp_q.pop_front();
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_ok got %b want 1", ok); end
    n_tests++; if (th != 3) begin n_fail++; $display("FAIL single_hrq_lat got %0d want 3", th); end
    n_tests++; if (tg != 1) begin n_fail++; $display("FAIL single_gnt_lat got %0d want 1", tg); end
    n_tests++; if (int'(ch) != e) begin n_fail++; $display("FAIL single_ch got %0d want %0d", ch, e); end
    n_tests++; if (dk !== 4'b1011) begin n_fail++; $display("FAIL single_dack got %b want 1011", dk); end
    n_tests++; if (st != 1) begin n_fail++; $display("FAIL single_starts got %0d want 1", st); end
    n_tests++; if (rel !== 2'b00) begin n_fail++; $display("FAIL single_release got %b want 00", rel); end
    n_tests++; if (rdk !== 4'b1111) begin n_fail++; $display("FAIL single_rel_dack got %b want 1111", rdk); end
  endtask

  task automatic test_back_to_back(input bit rot);
    bit ok; int th, tg, st; logic [1:0] ch, rel; logic [3:0] dk, rdk; int e;
    init_inputs(); do_reset();
    cmd_rotate = rot; dreq = 4'b1111;
    for (int i = 0; i < 4; i++) begin
`ifdef DMA_ROTATING_PRIORITY_EN
      exp_q.push_back(rot ? i : 0);
`else
      exp_q.push_back(0);
`endif
    end
    for (int i = 0; i < 4; i++) begin
      serve(1, ok, th, tg, ch, dk, st, rel, rdk);
      e = exp_q.pop_front();
      n_tests++; if (ok !== 1'b1 || int'(ch) != e) begin
        n_fail++; $display("FAIL b2b_rot%0d_%0d got ch %0d ok %b want %0d", rot, i, ch, ok, e);
      end
      n_tests++; if (rel !== 2'b00) begin n_fail++; $display("FAIL b2b_rel_%0d got %b want 00", i, rel); end
    end
    dreq = 4'b0000;
  endtask

  task automatic test_mask();
    bit ok; int th, tg, st, hi; logic [1:0] ch, rel; logic [3:0] dk, rdk; int e;
    init_inputs(); do_reset();
    dreq = 4'b0011; masked_channels = 4'b0001; exp_q.push_back(1);
    serve(1, ok, th, tg, ch, dk, st, rel, rdk);
    masked_channels = 4'b1111;
    e = exp_q.pop_front();
    n_tests++; if (ok !== 1'b1 || int'(ch) != e) begin n_fail++; $display("FAIL mask_ch got %0d want %0d", ch, e); end
    n_tests++; if (dk !== 4'b1101) begin n_fail++; $display("FAIL mask_dack got %b want 1101", dk); end
    hi = 0;
    repeat (8) begin @(negedge CLK); if (hrq !== 1'b0) hi++; end
    n_tests++; if (hi != 0) begin n_fail++; $display("FAIL mask_all_hrq got %0d high cycles want 0", hi); end
  endtask

  task automatic test_disable();
    bit ok; int th, tg, st, hi; logic [1:0] ch, rel; logic [3:0] dk, rdk;
    init_inputs(); do_reset();
    cmd_disable = 1'b1; dreq = 4'b0001;
    hi = 0;
    repeat (8) begin @(negedge CLK); if (hrq !== 1'b0) hi++; end
    n_tests++; if (hi != 0) begin n_fail++; $display("FAIL disable_hrq got %0d high cycles want 0", hi); end
    cmd_disable = 1'b0;
    serve(0, ok, th, tg, ch, dk, st, rel, rdk);
    n_tests++; if (ok !== 1'b1 || ch !== 2'd0) begin n_fail++; $display("FAIL enable_ch got %0d ok %b want 0", ch, ok); end
  endtask

  task automatic test_drop();
    bit ok; int th, tg, st, n, bad; logic [1:0] ch, rel; logic [3:0] dk, rdk;
    init_inputs(); do_reset();
    dreq = 4'b1000;
    n = 0;
    while (hrq !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    n_tests++; if (hrq !== 1'b1) begin n_fail++; $display("FAIL drop_hrq_rise got %b want 1", hrq); end
    dreq = 4'b0000;
    n = 0; bad = 0;
    while (hrq !== 1'b0 && n < 20) begin
      @(negedge CLK); n++;
      if (grant !== 1'b0 || dack !== 4'b1111) bad++;
    end
    n_tests++; if (n != 3) begin n_fail++; $display("FAIL drop_hrq_fall got %0d cycles want 3", n); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL drop_nodack got %0d bad cycles want 0", bad); end
    dreq = 4'b0010;
    serve(0, ok, th, tg, ch, dk, st, rel, rdk);
    n_tests++; if (ok !== 1'b1 || ch !== 2'd1) begin n_fail++; $display("FAIL drop_idle_ch got %0d ok %b want 1", ch, ok); end
  endtask

  task automatic test_polarity();
    bit ok; int th, tg, st; logic [1:0] ch, rel; logic [3:0] dk, rdk; int e;
    init_inputs();
    cmd_dreq_low = 1'b1; cmd_dack_high = 1'b1; dreq = 4'b1111;
    do_reset();
    dreq = 4'b1110; exp_q.push_back(0);
    repeat (3) @(negedge CLK);
    n_tests++; if (req_status !== 4'b0001) begin n_fail++; $display("FAIL pol_status got %b want 0001", req_status); end
    serve(0, ok, th, tg, ch, dk, st, rel, rdk);
    e = exp_q.pop_front();
    n_tests++; if (ok !== 1'b1 || int'(ch) != e) begin n_fail++; $display("FAIL pol_ch got %0d want %0d", ch, e); end
    n_tests++; if (dk !== 4'b0001) begin n_fail++; $display("FAIL pol_dack got %b want 0001", dk); end
    n_tests++; if (rdk !== 4'b0000) begin n_fail++; $display("FAIL pol_rel_dack got %b want 0000", rdk); end
  endtask

  task automatic test_reset_mid();
    bit ok; int th, tg, st, n; logic [1:0] ch, rel; logic [3:0] dk, rdk; int e;
    init_inputs(); do_reset();
    cmd_rotate = 1'b1; dreq = 4'b1111;
    serve(0, ok, th, tg, ch, dk, st, rel, rdk);
`ifdef DMA_ROTATING_PRIORITY_EN
    exp_q.push_back(1);
`else
    exp_q.push_back(0);
`endif
    n = 0;
    while (hrq !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    hlda = 1'b1;
    n = 0;
    while (grant !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    e = exp_q.pop_front();
    n_tests++; if (grant !== 1'b1 || int'(active_ch) != e) begin
      n_fail++; $display("FAIL mid_ch got %0d grant %b want %0d", active_ch, grant, e);
    end
    reset = 1'b0; #1;
    n_tests++; if ({hrq, grant, xfer_start} !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst_out got %b want 000", {hrq, grant, xfer_start});
    end
    n_tests++; if (dack !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_dack got %b want 1111", dack); end
    hlda = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    exp_q.push_back(0);
    serve(0, ok, th, tg, ch, dk, st, rel, rdk);
    e = exp_q.pop_front();
    n_tests++; if (ok !== 1'b1 || int'(ch) != e) begin n_fail++; $display("FAIL mid_ptr_ch got %0d want %0d", ch, e); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_empty got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    init_inputs();
    reset = 1'b0;
    test_reset();
    test_single();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_mask();
    test_disable();
    test_drop();
    test_polarity();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
